// File: rtl/train_step_ctrl_pkg.sv
// Shared types, Q8.8 constants and saturation helper for the SGD step controller.
package train_step_ctrl_pkg;

  localparam int unsigned Q_FRAC = 8;
  localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q_MIN = 16'sh8000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FWD_REQ,
    ST_FWD_WAIT,
    ST_LOSS,
    ST_BWD_REQ,
    ST_BWD_WAIT,
    ST_UPD_W,
    ST_UPD_B,
    ST_DONE,
    ST_ERR
  } state_e;

  // Clamp a 17-bit signed intermediate into the Q8.8 range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    logic signed [15:0] r;
    if (x > 17'sh07FFF) begin
      r = Q_MAX;
    end else if (x < 17'sh18000) begin
      r = Q_MIN;
    end else begin
      r = x[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/train_step_ctrl_sgd_elem.sv
// Single-element SGD update: param - (grad >>> lr_shift), saturated to Q8.8.
module train_step_ctrl_sgd_elem
  import train_step_ctrl_pkg::*;
(
  input  logic signed [15:0] param,
  input  logic signed [15:0] grad,
  input  logic        [3:0]  lr_shift,
  output logic signed [15:0] upd_c
);

  logic signed [15:0] step;

  // Arithmetic shift keeps the gradient sign; large shifts collapse to 0 or -1.
  always_comb begin
    step  = grad >>> lr_shift;
    upd_c = sat16(17'(param) - 17'(step));
  end

endmodule

// File: rtl/train_step_ctrl.sv
// Sequences one SGD step: forward, loss gradient, backward, in-place w/b update.
module train_step_ctrl
  import train_step_ctrl_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned M       = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load,
  input  logic [M*N*N*16-1:0]   w_init,
  input  logic [M*N*16-1:0]     b_init,
  input  logic [3:0]            lr_shift,
  input  logic [N*16-1:0]       target,
  output logic                  fwd_start,
  input  logic                  fwd_done,
  input  logic [N*16-1:0]       y,
  output logic                  bwd_start,
  input  logic                  bwd_done,
  input  logic [M*N*N*16-1:0]   dL_dw,
  input  logic [M*N*16-1:0]     dL_db,
  output logic [N*16-1:0]       dL_dy,
  output logic [M*N*N*16-1:0]   w,
  output logic [M*N*16-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           step_count
);

  localparam int unsigned VW    = N * 16;
  localparam int unsigned WW    = M * N * N * 16;
  localparam int unsigned BW    = M * N * 16;
  localparam int unsigned NW    = M * N * N;
  localparam int unsigned NB    = M * N;
  localparam int unsigned IDX_W = $clog2(NW + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [3:0]         lr_q, lr_d;
  logic [VW-1:0]      target_q, target_d;
  logic [VW-1:0]      y_q, y_d;
  logic [VW-1:0]      dl_dy_q, dl_dy_d;
  logic [WW-1:0]      w_q, w_d;
  logic [BW-1:0]      b_q, b_d;
  logic               fwd_start_q, fwd_start_d;
  logic               bwd_start_q, bwd_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        step_q, step_d;

  logic [31:0]        elem_ofs;
  logic signed [15:0] param_sel, grad_sel, upd_c;

  // One update element shared by the weight and bias phases.
  train_step_ctrl_sgd_elem u_sgd_elem (
    .param    (param_sel),
    .grad     (grad_sel),
    .lr_shift (lr_q),
    .upd_c    (upd_c)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    lr_d        = lr_q;
    target_d    = target_q;
    y_d         = y_q;
    dl_dy_d     = dl_dy_q;
    w_d         = w_q;
    b_d         = b_q;
    elem_ofs    = 32'(idx_q) * 32'd16;

    if (state_q == ST_UPD_B) begin
      param_sel = b_q[elem_ofs +: 16];
      grad_sel  = dL_db[elem_ofs +: 16];
    end else begin
      param_sel = w_q[elem_ofs +: 16];
      grad_sel  = dL_dw[elem_ofs +: 16];
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          w_d = w_init;
          b_d = b_init;
        end else if (start) begin
          target_d = target;
          lr_d     = lr_shift;
          state_d  = ST_FWD_REQ;
        end
      end
      ST_FWD_REQ: begin
        tmo_d   = '0;
        state_d = ST_FWD_WAIT;
      end
      ST_FWD_WAIT: begin
        if (fwd_done) begin
          y_d     = y;
          idx_d   = '0;
          state_d = ST_LOSS;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_LOSS: begin
        dl_dy_d[elem_ofs +: 16] = sat16(17'($signed(y_q[elem_ofs +: 16]))
                                      - 17'($signed(target_q[elem_ofs +: 16])));
        if (idx_q == IDX_W'(N - 1)) begin
          idx_d   = '0;
          state_d = ST_BWD_REQ;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_BWD_REQ: begin
        tmo_d   = '0;
        state_d = ST_BWD_WAIT;
      end
      ST_BWD_WAIT: begin
        if (bwd_done) begin
          idx_d   = '0;
          state_d = ST_UPD_W;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_UPD_W: begin
        w_d[elem_ofs +: 16] = upd_c;
        if (idx_q == IDX_W'(NW - 1)) begin
          idx_d   = '0;
          state_d = ST_UPD_B;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_UPD_B: begin
        b_d[elem_ofs +: 16] = upd_c;
        if (idx_q == IDX_W'(NB - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the state being entered.
    fwd_start_d = (state_d == ST_FWD_REQ);
    bwd_start_d = (state_d == ST_BWD_REQ);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_ERR);
    step_d      = (state_d == ST_DONE) ? step_q + 16'd1 : step_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      lr_q        <= '0;
      target_q    <= '0;
      y_q         <= '0;
      dl_dy_q     <= '0;
      w_q         <= '0;
      b_q         <= '0;
      fwd_start_q <= 1'b0;
      bwd_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      lr_q        <= lr_d;
      target_q    <= target_d;
      y_q         <= y_d;
      dl_dy_q     <= dl_dy_d;
      w_q         <= w_d;
      b_q         <= b_d;
      fwd_start_q <= fwd_start_d;
      bwd_start_q <= bwd_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      step_q      <= step_d;
    end
  end

  assign fwd_start  = fwd_start_q;
  assign bwd_start  = bwd_start_q;
  assign dL_dy      = dl_dy_q;
  assign w          = w_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_train_step_ctrl.sv
// Directed bench for train_step_ctrl with N=2, M=2, TIMEOUT=8.
module tb_train_step_ctrl;
  import train_step_ctrl_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned M   = 2;
  localparam int unsigned TMO = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                load = 1'b0;
  logic [M*N*N*16-1:0] w_init = '0;
  logic [M*N*16-1:0]   b_init = '0;
  logic [3:0]          lr_shift = '0;
  logic [N*16-1:0]     target = '0;
  logic                fwd_start;
  logic                fwd_done = 1'b0;
  logic [N*16-1:0]     y = '0;
  logic                bwd_start;
  logic                bwd_done = 1'b0;
  logic [M*N*N*16-1:0] dL_dw = '0;
  logic [M*N*16-1:0]   dL_db = '0;
  logic [N*16-1:0]     dL_dy;
  logic [M*N*N*16-1:0] w;
  logic [M*N*16-1:0]   b;
  logic                busy, done, err;
  logic [15:0]         step_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fwd_cnt = 0;
  int bwd_cnt = 0;
  int done_cnt = 0;

  train_step_ctrl #(.N(N), .M(M), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .load(load),
    .w_init(w_init), .b_init(b_init), .lr_shift(lr_shift), .target(target),
    .fwd_start(fwd_start), .fwd_done(fwd_done), .y(y),
    .bwd_start(bwd_start), .bwd_done(bwd_done), .dL_dw(dL_dw), .dL_db(dL_db),
    .dL_dy(dL_dy), .w(w), .b(b), .busy(busy), .done(done), .err(err),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Cycle counter and high-cycle counters for the pulse outputs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fwd_start) fwd_cnt <= fwd_cnt + 1;
    if (bwd_start) bwd_cnt <= bwd_cnt + 1;
    if (done)      done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] fill(input int n, input logic [15:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  // Runs one step with stub blocks: fwd_done in FWD_WAIT cycle f_res, bwd_done in BWD_WAIT cycle 1.
  // lat = cycles from FWD_REQ through DONE inclusive, 0 if done never came.
  task automatic run_step(input int f_res, input logic [N*16-1:0] y_val,
                          input bit hold_start, output int lat);
    int c0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
    tick();
    for (int i = 1; i < f_res; i++) tick();
    fwd_done = 1'b1;
    y = y_val;
    tick();
    fwd_done = 1'b0;
    y = '1;
    repeat (N) tick();
    if (hold_start) start = 1'b1;
    tick();
    bwd_done = 1'b1;
    tick();
    bwd_done = 1'b0;
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin
        lat = cyc - c0 + 1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int lat;
    int f0, b0, d0;
    logic [127:0] exp_w;
    logic [15:0] one;
    one = 16'(1 << Q_FRAC);

    // Reset state
    tick(); tick();
    check_eq("rst_w", 128'(w), 128'd0);
    check_eq("rst_b", 128'(b), 128'd0);
    check_eq("rst_flags", {125'd0, busy, done, err}, 128'd0);
    check_eq("rst_step", 128'(step_count), 128'd0);
    check_eq("rst_dldy", 128'(dL_dy), 128'd0);
    rst = 1'b0;
    tick();

    // load and start together: load wins, no forward request
    f0 = fwd_cnt;
    w_init = fill(8, one);
    b_init = '0;
    load = 1'b1;
    start = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b0;
    check_eq("load_w", 128'(w), fill(8, 16'h0100));
    check_eq("load_b", 128'(b), 128'd0);
    tick(); tick();
    check_eq("load_start_nofwd", 128'(fwd_cnt - f0), 128'd0);
    check_eq("load_start_idle", 128'(busy), 128'd0);

    // Spurious fwd_done in IDLE
    fwd_done = 1'b1;
    y = 32'hDEAD_BEEF;
    tick();
    fwd_done = 1'b0;
    tick();
    check_eq("spurious_done_idle", 128'(busy), 128'd0);

    // Main step: F=3, lr_shift=1, start held high in BWD_REQ/BWD_WAIT
    f0 = fwd_cnt; b0 = bwd_cnt; d0 = done_cnt;
    target = {16'h0100, 16'h0100};
    lr_shift = 4'd1;
    dL_dw = fill(8, 16'h0200);
    dL_db = fill(4, 16'h0100);
    run_step(3, {16'h0100, 16'h0300}, 1'b1, lat);
    check_eq("main_latency", 128'(lat), 128'd21);
    tick();
    check_eq("main_done_width", 128'(done), 128'd0);
    check_eq("main_dldy", 128'(dL_dy), {96'd0, 16'h0000, 16'h0200});
    check_eq("main_fwd_pulse", 128'(fwd_cnt - f0), 128'd1);
    check_eq("main_bwd_pulse", 128'(bwd_cnt - b0), 128'd1);
    check_eq("main_done_pulse", 128'(done_cnt - d0), 128'd1);
    check_eq("main_w", 128'(w), 128'd0);
    check_eq("main_b", 128'(b), fill(4, 16'hFF80));
    check_eq("main_step_cnt", 128'(step_count), 128'd1);
    check_eq("main_idle", 128'(busy), 128'd0);

    // Saturation in update and loss, lr_shift=0, F=1
    w_init = fill(8, 16'h0100);
    w_init[15:0] = 16'h8010;
    b_init = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    lr_shift = 4'd0;
    dL_dw = '0;
    dL_dw[15:0] = 16'h7FFF;
    dL_db = '0;
    dL_db[15:0] = 16'h8000;
    target = {16'hFF00, 16'h0100};
    run_step(1, {16'h7FFF, 16'h8000}, 1'b0, lat);
    check_eq("sat_latency", 128'(lat), 128'd19);
    exp_w = fill(8, 16'h0100);
    exp_w[15:0] = 16'h8000;
    check_eq("sat_w", 128'(w), exp_w);
    check_eq("sat_b", 128'(b), {64'd0, 48'd0, 16'h7FFF});
    check_eq("sat_dldy", 128'(dL_dy), {96'd0, 16'h7FFF, 16'h8000});
    check_eq("sat_step_cnt", 128'(step_count), 128'd2);
    tick();

    // lr_shift=15: positive gradients vanish, negative ones become -1
    w_init = fill(8, 16'h0100);
    b_init = fill(4, 16'h0010);
    load = 1'b1;
    tick();
    load = 1'b0;
    lr_shift = 4'd15;
    dL_dw = fill(8, 16'h0200);
    dL_db = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    target = '0;
    run_step(2, '0, 1'b0, lat);
    check_eq("lr15_latency", 128'(lat), 128'd20);
    check_eq("lr15_w", 128'(w), fill(8, 16'h0100));
    check_eq("lr15_b", 128'(b), {64'd0, 16'h0010, 16'h0011, 16'h0010, 16'h0011});
    tick();

    // Reset during UPD_W at k=3
    w_init = fill(8, 16'h0100);
    b_init = fill(4, 16'h0100);
    load = 1'b1;
    tick();
    load = 1'b0;
    lr_shift = 4'd1;
    dL_dw = fill(8, 16'h0200);
    dL_db = fill(4, 16'h0100);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    fwd_done = 1'b1;
    tick();
    fwd_done = 1'b0;
    tick(); tick();
    tick();
    bwd_done = 1'b1;
    tick();
    bwd_done = 1'b0;
    tick(); tick(); tick();
    exp_w = fill(8, 16'h0100);
    exp_w[47:0] = '0;
    check_eq("midupd_w_k3", 128'(w), exp_w);
    check_eq("midupd_busy", 128'(busy), 128'd1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_wb", {w, b}, 192'd0);
    check_eq("abort_flags", {125'd0, busy, done, err}, 128'd0);
    check_eq("abort_step_cnt", 128'(step_count), 128'd0);
    repeat (30) tick();
    check_eq("abort_no_done", 128'(done_cnt - d0), 128'd0);

    // Timeout: forward block never answers
    w_init = fill(8, 16'h1234);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (TMO - 1) tick();
    check_eq("tmo_before", {126'd0, busy, err}, 128'd2);
    tick();
    check_eq("tmo_err", {126'd0, busy, err}, 128'd1);
    f0 = fwd_cnt;
    start = 1'b1;
    load = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    load = 1'b0;
    check_eq("err_sticky", {126'd0, busy, err}, 128'd1);
    check_eq("err_ignores_start", 128'(fwd_cnt - f0), 128'd0);
    check_eq("err_ignores_load", 128'(w), 128'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("err_cleared", {126'd0, busy, err}, 128'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("idle_after_err", 128'(w), fill(8, 16'h1234));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
